// File: rtl/sp_ram_pkg.sv
// Shared constants for the single-port RAM.
// The module's width parameters take their default values from here.
package sp_ram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

endpackage : sp_ram_pkg

// File: rtl/sp_ram.sv
// Single-port flip-flop RAM with write-first registered read data.
// clear_n asynchronously zeroes the whole array and the read register.
module sp_ram
  import sp_ram_pkg::*;
#(
  parameter int n = DATA_W,
  parameter int m = ADDR_W
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         WE,
  input  logic [m-1:0] Address,
  input  logic [n-1:0] D,
  output logic [n-1:0] Q
);

  localparam int DEPTH = 2 ** m;

  logic [n-1:0] mem_q [DEPTH];
  logic [n-1:0] mem_d [DEPTH];
  logic [n-1:0] q_q;
  logic [n-1:0] q_d;

  // Next state: a write updates one word and forwards D to Q; a read never looks at D.
  always_comb begin
    mem_d = mem_q;
    q_d   = q_q;
    if (WE) begin
      mem_d[Address] = D;
      q_d            = D;
    end else begin
      q_d = mem_q[Address];
    end
  end

  // Array and read register share one async-reset process so a clear wipes both at once.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      q_q <= '0;
    end else begin
      mem_q <= mem_d;
      q_q   <= q_d;
    end
  end

  assign Q = q_q;

endmodule : sp_ram

// File: tb/tb_sp_ram.sv
// Scoreboard bench for sp_ram: an 8-bit default instance and a 16-bit instance
// share clk, clear_n, WE and Address; the monitor checks Q one edge after each issue.
module tb_sp_ram;

  typedef struct {
    logic        chk8;
    logic [7:0]  e8;
    logic        chk16;
    logic [15:0] e16;
    string       name;
  } exp_t;

  logic        clk;
  logic        clear_n;
  logic        we;
  logic [4:0]  addr;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic [7:0]  q8;
  logic [15:0] q16;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  sp_ram u_dut8 (
    .clk     (clk),
    .clear_n (clear_n),
    .WE      (we),
    .Address (addr),
    .D       (d8),
    .Q       (q8)
  );

  sp_ram #(.n(16), .m(5)) u_dut16 (
    .clk     (clk),
    .clear_n (clear_n),
    .WE      (we),
    .Address (addr),
    .D       (d16),
    .Q       (q16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one operation for the coming rising edge and queue its expected Q.
  task automatic op(input logic w, input logic [4:0] a, input logic [7:0] v8,
                    input logic [15:0] v16, input logic c8, input logic [7:0] e8,
                    input logic c16, input logic [15:0] e16, input string name);
    exp_t e;
    @(negedge clk);
    we   = w;
    addr = a;
    d8   = v8;
    d16  = v16;
    e.chk8 = c8; e.e8 = e8; e.chk16 = c16; e.e16 = e16; e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 16'(sb.size()), 16'h0000);
      sb.delete();
    end
    we = 1'b0;
  endtask

  // Monitor: every rising edge that had an operation issued presents a fresh Q.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk8)  check({e.name, "_q8"},  {8'h00, q8}, {8'h00, e.e8});
      if (e.chk16) check({e.name, "_q16"}, q16, e.e16);
    end
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    clear_n = 1'b1;
    we      = 1'b0;
    addr    = 5'h00;
    d8      = 8'h00;
    d16     = 16'h0000;

    // Put something in memory so the reset has something to wipe.
    op(1'b1, 5'h0A, 8'h77, 16'h7777, 1'b1, 8'h77, 1'b1, 16'h7777, "pre_wr");
    drain();

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    clear_n = 1'b0;
    #1;
    check("async_rst_q8",  {8'h00, q8}, 16'h0000);
    check("async_rst_q16", q16, 16'h0000);
    #1;
    clear_n = 1'b1;
    for (int i = 0; i < 32; i++)
      op(1'b0, 5'(i), 8'h00, 16'h0000, 1'b1, 8'h00, 1'b1, 16'h0000, $sformatf("rst_rd%0d", i));
    drain();

    // Write sweep (write-first Q) then read-back sweep.
    for (int i = 0; i < 5; i++)
      op(1'b1, 5'(i), 8'(i), 16'(i), 1'b1, 8'(i), 1'b0, 16'h0000, $sformatf("sw_wr%0d", i));
    for (int i = 0; i < 5; i++)
      op(1'b0, 5'(i), 8'h00, 16'h0000, 1'b1, 8'(i), 1'b0, 16'h0000, $sformatf("sw_rd%0d", i));
    drain();

    op(1'b1, 5'h1F, 8'hA5, 16'h0000, 1'b1, 8'hA5, 1'b0, 16'h0000, "wf_wr");
    op(1'b0, 5'h1F, 8'h00, 16'h0000, 1'b1, 8'hA5, 1'b0, 16'h0000, "wf_rd");
    drain();

    // Reads with unknown D must not disturb memory.
    op(1'b0, 5'h02, 8'hxx, 16'hxxxx, 1'b1, 8'h02, 1'b0, 16'h0000, "rdx_a2");
    for (int i = 0; i < 5; i++)
      op(1'b0, 5'(i), 8'h00, 16'h0000, 1'b1, 8'(i), 1'b0, 16'h0000, $sformatf("rdx_chk%0d", i));
    drain();

    // Mid-run reset held across an edge with a write pending.
    @(negedge clk);
    we      = 1'b1;
    addr    = 5'h03;
    d8      = 8'h55;
    d16     = 16'h5555;
    clear_n = 1'b0;
    #1;
    check("mid_rst_q8", {8'h00, q8}, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_hold_q8",  {8'h00, q8}, 16'h0000);
    check("rst_hold_q16", q16, 16'h0000);
    @(negedge clk);
    we      = 1'b0;
    clear_n = 1'b1;
    op(1'b0, 5'h03, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b1, 16'h0000, "post_rst_a3");
    op(1'b0, 5'h1F, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b0, 16'h0000, "post_rst_a1f");
    drain();

    // 16-bit instance round trip.
    op(1'b1, 5'h07, 8'h11, 16'hBEEF, 1'b1, 8'h11, 1'b1, 16'hBEEF, "w16_wr");
    op(1'b0, 5'h06, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b1, 16'h0000, "w16_rd6");
    op(1'b0, 5'h07, 8'h00, 16'h0000, 1'b1, 8'h11, 1'b1, 16'hBEEF, "w16_rd7");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sp_ram
